// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with debug read port and sequential bulk clear.
// Optional REGFILE_BYPASS_EN: same-cycle write-through forwarding on rd1/rd2 (never dbg_rd).
module reg_file_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] dbg_ra,
    input  logic              clr_req,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] dbg_rd,
    output logic              busy,
    output logic              wr_drop
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam bit          ZeroReg = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        StIdle,
        StClear
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_busy;
    logic              r_wr_drop;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_wr_en;
    logic              w_clr_en;
    logic [DATA_W-1:0] w_rd1_mem;
    logic [DATA_W-1:0] w_rd2_mem;
    logic [DATA_W-1:0] w_dbg_mem;

    // Writes are blocked while sweeping and, with ZeroReg, to address 0.
    assign w_wr_en  = we3 && !r_busy && !(ZeroReg && (wa3 == '0));
    assign w_clr_en = (r_state == StClear);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= StIdle;
            r_clr_ptr <= '0;
            r_busy    <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= we3 && r_busy;
            unique case (r_state)
                StIdle: begin
                    if (clr_req) begin
                        r_state   <= StClear;
                        r_clr_ptr <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                StClear: begin
                    r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                    if (r_clr_ptr == LastAddr) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A write and a sweep step never coincide: writes require busy low.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[wa3] <= wd3;
            end
            if (w_clr_en) begin
                r_mem[r_clr_ptr] <= '0;
            end
        end
    end

    always_comb begin
        w_rd1_mem = r_mem[ra1];
        w_rd2_mem = r_mem[ra2];
        w_dbg_mem = r_mem[dbg_ra];
        if (ZeroReg && (ra1 == '0)) w_rd1_mem = '0;
        if (ZeroReg && (ra2 == '0)) w_rd2_mem = '0;
        if (ZeroReg && (dbg_ra == '0)) w_dbg_mem = '0;
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rd1 = w_rd1_mem;
        rd2 = w_rd2_mem;
        if (w_wr_en && (ra1 == wa3)) rd1 = wd3;
        if (w_wr_en && (ra2 == wa3)) rd2 = wd3;
    end
`else
    always_comb begin
        rd1 = w_rd1_mem;
        rd2 = w_rd2_mem;
    end
`endif

    assign dbg_rd  = w_dbg_mem;
    assign busy    = r_busy;
    assign wr_drop = r_wr_drop;

endmodule
